esc_pwm_gen: RTL and testbench
==============================

Name: esc_pwm_gen

Overview:
Downstream of the RC-receiver channel decoder. Consumes the 13-bit 0..1000 throttle command that the decoder produces and drives one ESC with a standard servo-style PWM frame: pulse width of MIN_US + cmd microseconds, repeated every FRAME_US.
- Includes an arming state machine, so the motor cannot spin up at power-on or when the stick is not at idle.
- One instance per motor.

Parameters:
CLK_PER_US, 50, clock cycles per microsecond (50 MHz system clock)
FRAME_US, 20000, PWM frame period in us (50 Hz)
MIN_US, 1000, pulse width in us at zero command / disarmed
CMD_MAX, 1000, command clamp ceiling (max pulse = MIN_US+CMD_MAX)
ARM_THRESH, 20, command at or below this counts as "stick idle" for arming
ARM_FRAMES, 50, consecutive idle frames needed to arm (1 s)
SLEW_STEP, 10, max command change per frame (optional feature only)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
cmd  in  13  throttle command from channel decoder, nominal 0..1000, any value tolerated
arm_req  in  1  level; 1 = pilot requests armed, 0 = force disarm
pwm_out  out  1  ESC pulse output
armed  out  1  1 while in ARMED state
frame_tick  out  1  one-cycle pulse on the first cycle of each frame
latched_cmd  out  13  command in effect for the current frame

Behaviour:
- Reset (rst_n=0 at a clk edge): pwm_out=0, armed=0, frame_tick=0, latched_cmd=0, prescaler=0, us counter=0, arm count=0, state=DISARMED. Reset asserted mid-pulse drops pwm_out at that edge with no completion of the pulse.
- Timebase: prescaler counts 0..CLK_PER_US-1; us counter advances when the prescaler wraps and counts 0..FRAME_US-1. Frame period is exactly FRAME_US*CLK_PER_US cycles.
- Frame edge: the edge on which the us counter wraps to 0. The first frame edge is the first clk edge with rst_n=1. At each frame edge:
  - cmd is sampled once.
  - cmd is clamped to CMD_MAX: values 1001..8191 become 1000.
  - The state machine updates.
  - width_us is latched.
- Mid-frame changes to cmd or arm_req have no effect until the next frame edge.
- Outputs are registered. frame_tick=1 and pwm_out rises in the cycle following the frame edge. pwm_out stays high exactly width_us*CLK_PER_US cycles, then stays low for the rest of the frame.
- State machine, evaluated at the frame edge with the clamped sample c:
  - DISARMED: if arm_req=1 and c<=ARM_THRESH, go to ARMING with count=1; otherwise stay.
  - ARMING: if arm_req=0, go to DISARMED. Else if c>ARM_THRESH, go to DISARMED with count=0. Else count++; on reaching ARM_FRAMES, go to ARMED.
  - ARMED: if arm_req=0, go to DISARMED; otherwise stay.
- Width is computed from the new state:
  - ARMED: latched_cmd=c, width_us=MIN_US+latched_cmd.
  - Otherwise: latched_cmd=0, width_us=MIN_US.
- The first armed pulse occurs in the frame whose edge completes ARM_FRAMES idle samples.
- armed mirrors state==ARMED and changes in the frame_tick cycle.
- Width arithmetic is 16-bit unsigned. MIN_US+CMD_MAX must be < FRAME_US, so the output never stays high for a full frame.

Optional Feature:
Macro ESC_SLEW_LIMIT_EN.
- Defined: while ARMED, latched_cmd moves toward c by at most SLEW_STEP per frame: latched_cmd += min(c−latched_cmd, SLEW_STEP) upward, and symmetrically downward. On leaving ARMED, latched_cmd is forced to 0 immediately; disarm is never slewed.
- Undefined: latched_cmd = c directly and SLEW_STEP is unused.

Test Plan:
All tests use CLK_PER_US=2, FRAME_US=3000, ARM_FRAMES=4.
1. Reset release with arm_req=0, cmd=500 → pwm_out high exactly 2000 cycles, period 6000 cycles, armed=0, latched_cmd=0 for 10 frames.
2. arm_req=1, cmd=0 → armed=1 at the 4th frame_tick. Then cmd=600 → next frame pulse is 3200 cycles, latched_cmd=600.
3. Arming interrupted: cmd=0 for 3 frames, then cmd=100 for 1 frame, then 0 → armed only after 4 fresh idle frames, 8 frames total.
4. Armed, cmd=5000 → clamped: latched_cmd=1000, pulse 4000 cycles. cmd changed mid-frame → current pulse unchanged.
5. Armed at cmd=800, arm_req→0 mid-frame → current 3600-cycle pulse completes, next frame 2000 cycles, armed=0. rst_n low mid-pulse → pwm_out=0 on the next edge.
6. (ESC_SLEW_LIMIT_EN) Armed, cmd step 0→100 → latched_cmd 10,20,…,100 over 10 frames. Disarm → 0 in one frame.

Source files
------------

// File: rtl/esc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : esc_pwm_gen
// Brief    : Servo-style ESC PWM generator with arming FSM; ESC_SLEW_LIMIT_EN
//            enables per-frame slew limiting of the armed command.
// Revision : 1.0 - initial release
// ============================================================================
module esc_pwm_gen #(
    parameter int CLK_PER_US = 50,
    parameter int FRAME_US   = 20000,
    parameter int MIN_US     = 1000,
    parameter int CMD_MAX    = 1000,
    parameter int ARM_THRESH = 20,
    parameter int ARM_FRAMES = 50,
    parameter int SLEW_STEP  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] cmd,
    input  logic        arm_req,
    output logic        pwm_out,
    output logic        armed,
    output logic        frame_tick,
    output logic [12:0] latched_cmd
);

    localparam int c_PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int c_US_W  = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
    localparam int c_CNT_W = $clog2(ARM_FRAMES + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST   = c_PRE_W'(CLK_PER_US - 1);
    localparam logic [c_US_W-1:0]  c_US_LAST    = c_US_W'(FRAME_US - 1);
    localparam logic [12:0]        c_CMD_MAX    = 13'(CMD_MAX);
    localparam logic [12:0]        c_ARM_THRESH = 13'(ARM_THRESH);
    localparam logic [12:0]        c_SLEW       = 13'(SLEW_STEP);
    localparam logic [15:0]        c_MIN_US     = 16'(MIN_US);
    localparam logic [c_CNT_W-1:0] c_ARM_FRAMES = c_CNT_W'(ARM_FRAMES);

`ifdef ESC_SLEW_LIMIT_EN
    localparam bit c_SLEW_EN = 1'b1;
`else
    localparam bit c_SLEW_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_arm_cnt;
    logic [c_CNT_W-1:0]  w_cnt_next;
    logic [c_PRE_W-1:0]  r_pre;
    logic [c_US_W-1:0]   r_us;
    logic [12:0]         r_latched;
    logic [12:0]         w_latched_next;
    logic [15:0]         r_width;
    logic [15:0]         w_width_next;
    logic                r_pwm;
    logic                r_tick;
    logic                w_frame_edge;
    logic [12:0]         w_clamped;
    logic                w_idle;

    // Counters sit at zero out of reset, so the first released edge starts a frame.
    assign w_frame_edge = (r_pre == '0) && (r_us == '0);
    assign w_clamped    = (cmd > c_CMD_MAX) ? c_CMD_MAX : cmd;
    assign w_idle       = (w_clamped <= c_ARM_THRESH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_DISARMED;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_arm_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_arm_cnt;
        if (w_frame_edge) begin
            case (r_state)
                ST_DISARMED: begin
                    if (arm_req && w_idle) begin
                        w_cnt_next   = c_CNT_W'(1);
                        w_state_next = (ARM_FRAMES <= 1) ? ST_ARMED : ST_ARMING;
                    end
                end
                ST_ARMING: begin
                    if (!arm_req || !w_idle) begin
                        w_state_next = ST_DISARMED;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_arm_cnt + 1'b1;
                        if (w_cnt_next >= c_ARM_FRAMES) begin
                            w_state_next = ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (!arm_req) begin
                        w_state_next = ST_DISARMED;
                        w_cnt_next   = '0;
                    end
                end
                default: begin
                    w_state_next = ST_DISARMED;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Command follows the new state; leaving ARMED always drops straight to zero.
    always_comb begin
        w_latched_next = 13'd0;
        if (w_state_next == ST_ARMED) begin
            if (!c_SLEW_EN) begin
                w_latched_next = w_clamped;
            end else if (w_clamped > r_latched) begin
                w_latched_next = ((w_clamped - r_latched) > c_SLEW) ? (r_latched + c_SLEW) : w_clamped;
            end else begin
                w_latched_next = ((r_latched - w_clamped) > c_SLEW) ? (r_latched - c_SLEW) : w_clamped;
            end
        end
        w_width_next = c_MIN_US + 16'(w_latched_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre     <= '0;
            r_us      <= '0;
            r_latched <= '0;
            r_width   <= '0;
            r_pwm     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
                r_us  <= (r_us == c_US_LAST) ? '0 : r_us + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
            r_tick <= w_frame_edge;
            // High while the elapsed whole microseconds are below the width.
            if (w_frame_edge) begin
                r_latched <= w_latched_next;
                r_width   <= w_width_next;
                r_pwm     <= (w_width_next != 16'd0);
            end else begin
                r_pwm <= (16'(r_us) < r_width);
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign armed       = (r_state == ST_ARMED);
    assign frame_tick  = r_tick;
    assign latched_cmd = r_latched;

endmodule
`default_nettype wire

// File: tb/tb_esc_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_esc_pwm_gen
// Brief    : Self-checking bench for esc_pwm_gen against a per-frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esc_pwm_gen;

    // Scaled-down timebase so a few dozen frames stay short.
    localparam int CPU       = 2;
    localparam int FUS       = 300;
    localparam int MIN       = 100;
    localparam int CMAX      = 150;
    localparam int THR       = 20;
    localparam int AF        = 4;
    localparam int SLEW      = 10;
    localparam int FRAME_CYC = FUS * CPU;

    logic        clk;
    logic        rst_n;
    logic [12:0] cmd;
    logic        arm_req;
    logic        pwm_out;
    logic        armed;
    logic        frame_tick;
    logic [12:0] latched_cmd;

    int checks = 0;
    int errors = 0;

    // Behavioural model: consecutive idle run length, armed flag, commanded value.
    int m_run   = 0;
    bit m_armed = 1'b0;
    int m_lat   = 0;

    esc_pwm_gen #(
        .CLK_PER_US (CPU),
        .FRAME_US   (FUS),
        .MIN_US     (MIN),
        .CMD_MAX    (CMAX),
        .ARM_THRESH (THR),
        .ARM_FRAMES (AF),
        .SLEW_STEP  (SLEW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd),
        .arm_req     (arm_req),
        .pwm_out     (pwm_out),
        .armed       (armed),
        .frame_tick  (frame_tick),
        .latched_cmd (latched_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 0;
        m_armed = 1'b0;
        m_lat   = 0;
    endtask

    task automatic model_frame(input int c_raw, input bit arm);
        int c;
        c = (c_raw > CMAX) ? CMAX : c_raw;
        if (!arm) begin
            m_armed = 1'b0;
            m_run   = 0;
        end else if (!m_armed) begin
            if (c <= THR) begin
                m_run++;
                if (m_run >= AF) m_armed = 1'b1;
            end else begin
                m_run = 0;
            end
        end
        if (!m_armed) begin
            m_lat = 0;
        end else begin
`ifdef ESC_SLEW_LIMIT_EN
            if (c - m_lat > SLEW)       m_lat = m_lat + SLEW;
            else if (m_lat - c > SLEW)  m_lat = m_lat - SLEW;
            else                        m_lat = c;
`else
            m_lat = c;
`endif
        end
    endtask

    function automatic int rand_cmd();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, THR));
            1:       return int'($urandom_range(0, CMAX));
            2:       return int'($urandom_range(CMAX + 1, 8191));
            default: return int'($urandom_range(0, 8191));
        endcase
    endfunction

    // Called at a negedge just before a frame edge; returns at the negedge before the next one.
    task automatic run_frame(input int c_raw, input bit arm);
        int exp_w;
        int hi_cnt;
        int bad_shape;
        int extra;
        cmd     = 13'(c_raw);
        arm_req = arm;
        model_frame(c_raw, arm);
        exp_w     = (MIN + m_lat) * CPU;
        hi_cnt    = 0;
        bad_shape = 0;
        extra     = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                check("frame_tick", frame_tick, 1);
                check("armed", armed, int'(m_armed));
                check("latched_cmd", latched_cmd, m_lat);
            end else if (frame_tick !== 1'b0 || armed !== m_armed || latched_cmd !== 13'(m_lat)) begin
                extra++;
            end
            if (pwm_out === 1'b1) begin
                hi_cnt++;
                if (i >= exp_w) bad_shape++;
            end else if (i < exp_w) begin
                bad_shape++;
            end
            if (i == FRAME_CYC / 3) begin
                cmd     = 13'($urandom);
                arm_req = 1'($urandom);
            end
        end
        check("pulse_cycles", hi_cnt, exp_w);
        check("pulse_shape", bad_shape, 0);
        check("midframe_stable", extra, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        cmd     = 13'd0;
        arm_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_armed", armed, 0);
        check("rst_tick", frame_tick, 0);
        check("rst_latched", latched_cmd, 0);

        // Disarmed frames regardless of command
        rst_n = 1'b1;
        run_frame(500, 1'b0);
        run_frame(8191, 1'b0);
        run_frame(0, 1'b0);

        // Arm with idle stick, threshold value counts as idle
        run_frame(0, 1'b1);
        run_frame(THR, 1'b1);
        run_frame($urandom_range(0, THR), 1'b1);
        check("not_armed_3", armed, 0);
        run_frame($urandom_range(0, THR), 1'b1);
        check("armed_after_4", armed, 1);

        // Armed commands including clamp boundaries
        run_frame(600, 1'b1);
        run_frame(8191, 1'b1);
        run_frame(CMAX, 1'b1);
        run_frame(CMAX + 1, 1'b1);
        for (int k = 0; k < 4; k++) run_frame(rand_cmd(), 1'b1);

        run_frame(rand_cmd(), 1'b0);
        check("disarmed", armed, 0);

        // Interrupted arming: threshold+1 restarts the idle run
        for (int k = 0; k < 3; k++) run_frame(0, 1'b1);
        run_frame(THR + 1, 1'b1);
        for (int k = 0; k < 3; k++) run_frame(0, 1'b1);
        check("interrupted_not_armed", armed, 0);
        run_frame(0, 1'b1);
        check("interrupted_armed", armed, 1);

        // Step response while armed
        for (int k = 0; k < 11; k++) run_frame(100, 1'b1);

        // Arm request dropped while arming
        run_frame(0, 1'b0);
        run_frame(0, 1'b1);
        run_frame(0, 1'b1);
        run_frame(0, 1'b0);
        for (int k = 0; k < 4; k++) run_frame(0, 1'b1);
        check("rearmed", armed, 1);

        // Random mix
        for (int k = 0; k < 12; k++) run_frame(rand_cmd(), ($urandom_range(0, 9) != 0));

        // Reset in the middle of a pulse
        cmd     = 13'd50;
        arm_req = 1'b1;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset_pwm", pwm_out, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midpulse_rst_pwm", pwm_out, 0);
        check("midpulse_rst_armed", armed, 0);
        check("midpulse_rst_latched", latched_cmd, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
